// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, widths, immediate kinds and
// the ID/EX pipeline register layout.
package core_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } id_ex_t;

    // A bubble decodes as a non-valid NOP so downstream stages see no side effects.
    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b        = '0;
        b.opcode = OP_IMM;
        return b;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/writeback/hazard inputs and decoded ID/EX outputs of the decode stage.
interface id_stage_if;
    import core_pkg::*;

    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_in;
    logic            stall;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            valid_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;

    modport master (
        output instruction, pc_in, stall, flush, wb_en, wb_rd, wb_data,
        input  valid_out, pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd,
               opcode, funct3, funct7, illegal
    );

    modport slave (
        input  instruction, pc_in, stall, flush, wb_en, wb_rd, wb_data,
        output valid_out, pc_out, rs1_data, rs2_data, imm, rs1, rs2, rd,
               opcode, funct3, funct7, illegal
    );

endinterface

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports with
// write-through bypass, one write port, x0 hardwired to zero.
module regfile
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != 5'd0);

    // NOTE: the array is cleared by reset because software relies on all
    // registers reading zero after reset; <= keeps every flop update race-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)                   return '0;
        else if (wr_live && wr_addr == addr) return wr_data;
        else                                return regs[addr];
    endfunction

    assign rs1_data = read_port(rs1_addr);
    assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register-file read, immediate
// generation and the ID/EX output register, with stall/flush handling.
module id_stage
    import core_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            vld_q;

    // Flush outranks stall so a held instruction on a wrong path is dropped.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            vld_q   <= 1'b0;
        end else if (!bus.stall) begin
            instr_q <= bus.instruction;
            pc_q    <= bus.pc_in;
            vld_q   <= 1'b1;
        end
    end

    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;
    logic            illegal;

    assign opcode = instr_q[6:0];

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr_q[19:15]),
        .rs2_addr (instr_q[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .wr_en    (bus.wb_en),
        .wr_addr  (bus.wb_rd),
        .wr_data  (bus.wb_data)
    );

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
            OP_STORE:                 imm_type = IMM_S;
            OP_BRANCH:                imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         imm_type = IMM_U;
            OP_JAL:                   imm_type = IMM_J;
            OP_REG, OP_SYSTEM:        imm_type = IMM_NONE;
            default:                  illegal  = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S: imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B: imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_U: imm = {instr_q[31:12], 12'b0};
            IMM_J: imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                          instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    id_ex_t id_ex_q;

    always_ff @(posedge clk) begin
        if (rst || bus.stall || bus.flush) begin
            id_ex_q <= id_ex_bubble();
        end else begin
            id_ex_q.valid    <= vld_q;
            id_ex_q.pc       <= pc_q;
            id_ex_q.rs1_data <= rs1_val;
            id_ex_q.rs2_data <= rs2_val;
            id_ex_q.imm      <= imm;
            id_ex_q.rs1      <= instr_q[19:15];
            id_ex_q.rs2      <= instr_q[24:20];
            id_ex_q.rd       <= instr_q[11:7];
            id_ex_q.opcode   <= opcode;
            id_ex_q.funct3   <= instr_q[14:12];
            id_ex_q.funct7   <= instr_q[31:25];
            id_ex_q.illegal  <= illegal;
        end
    end

    assign bus.valid_out = id_ex_q.valid;
    assign bus.pc_out    = id_ex_q.pc;
    assign bus.rs1_data  = id_ex_q.rs1_data;
    assign bus.rs2_data  = id_ex_q.rs2_data;
    assign bus.imm       = id_ex_q.imm;
    assign bus.rs1       = id_ex_q.rs1;
    assign bus.rs2       = id_ex_q.rs2;
    assign bus.rd        = id_ex_q.rd;
    assign bus.opcode    = id_ex_q.opcode;
    assign bus.funct3    = id_ex_q.funct3;
    assign bus.funct7    = id_ex_q.funct7;
    assign bus.illegal   = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, immediates, bypass,
// x0, stall, flush, illegal opcodes and mid-run reset.
module tb_id_stage;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    id_stage_if bus();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.instruction = instr;
        bus.pc_in       = pc;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"},  {31'b0, bus.valid_out}, 32'h0);
        check({tag, ".opcode"}, {25'b0, bus.opcode},    32'h13);
        check({tag, ".pc"},     bus.pc_out,             32'h0);
        check({tag, ".imm"},    bus.imm,                32'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'h0;
        present(32'h0000_0013, 32'h0);
        #1;
        tick();
        tick();
        rst = 1'b0;
        check_bubble("reset");
        check("reset.rd", {27'b0, bus.rd}, 32'h0);

        // x5 written while addi x6,x5,-1 is latched into IF/ID
        bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_1234;
        present(32'hFFF2_8313, 32'h40);
        tick();
        bus.wb_en = 1'b0;
        tick();
        check("addi.valid", {31'b0, bus.valid_out}, 32'h1);
        check("addi.pc",    bus.pc_out,             32'h40);
        check("addi.rs1d",  bus.rs1_data,           32'h0000_1234);
        check("addi.imm",   bus.imm,                32'hFFFF_FFFF);
        check("addi.rd",    {27'b0, bus.rd},        32'd6);
        check("addi.rs1",   {27'b0, bus.rs1},       32'd5);
        check("addi.ill",   {31'b0, bus.illegal},   32'h0);

        present(32'h0020_A423, 32'h44); tick(); tick();
        check("sw.imm",     bus.imm,                32'h8);
        check("sw.funct3",  {29'b0, bus.funct3},    32'd2);
        check("sw.rs2",     {27'b0, bus.rs2},       32'd2);
        present(32'hFE00_0EE3, 32'h48); tick(); tick();
        check("beq.imm",    bus.imm,                32'hFFFF_FFFC);
        present(32'hABCD_E0B7, 32'h4C); tick(); tick();
        check("lui.imm",    bus.imm,                32'hABCD_E000);
        check("lui.rd",     {27'b0, bus.rd},        32'd1);
        present(32'h0010_006F, 32'h50); tick(); tick();
        check("jal.imm",    bus.imm,                32'h0000_0800);

        // add x8,x7,x0 reads x7 through the bypass in its IF/ID cycle
        present(32'h0003_8433, 32'h60); tick();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hDEAD_BEEF;
        tick();
        bus.wb_en = 1'b0;
        check("byp.rs1d",   bus.rs1_data,           32'hDEAD_BEEF);
        check("byp.rs2d",   bus.rs2_data,           32'h0);
        check("byp.rd",     {27'b0, bus.rd},        32'd8);
        check("byp.imm",    bus.imm,                32'h0);

        // add x9,x0,x0 while x0 is written, then again afterwards
        present(32'h0000_04B3, 32'h64); tick();
        bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
        tick();
        bus.wb_en = 1'b0;
        check("x0.same.rs1d", bus.rs1_data, 32'h0);
        check("x0.same.rs2d", bus.rs2_data, 32'h0);
        tick();
        check("x0.after.rs1d", bus.rs1_data, 32'h0);

        // or x10,x5,x7 held for two stall cycles; addi x11,x0,5 queued behind it
        present(32'h0072_E533, 32'h100); tick();
        present(32'h0050_0593, 32'h104);
        bus.stall = 1'b1;
        tick();
        check("stall1.valid", {31'b0, bus.valid_out}, 32'h0);
        tick();
        check("stall2.valid", {31'b0, bus.valid_out}, 32'h0);
        bus.stall = 1'b0;
        tick();
        present(32'h0000_0013, 32'h108);
        check("or.valid",   {31'b0, bus.valid_out}, 32'h1);
        check("or.pc",      bus.pc_out,             32'h100);
        check("or.rs1d",    bus.rs1_data,           32'h0000_1234);
        check("or.rs2d",    bus.rs2_data,           32'hDEAD_BEEF);
        check("or.funct3",  {29'b0, bus.funct3},    32'd6);
        tick();
        check("next.valid", {31'b0, bus.valid_out}, 32'h1);
        check("next.pc",    bus.pc_out,             32'h104);
        check("next.imm",   bus.imm,                32'h5);
        check("next.rd",    {27'b0, bus.rd},        32'd11);

        // xor x12,x1,x2 held in IF/ID, then flushed while stalled
        present(32'h0020_C633, 32'h200); tick();
        present(32'h0070_0693, 32'h300);
        bus.stall = 1'b1; bus.flush = 1'b1;
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0;
        check_bubble("flush1");
        tick();
        check_bubble("flush2");
        tick();
        check("postflush.valid", {31'b0, bus.valid_out}, 32'h1);
        check("postflush.pc",    bus.pc_out,             32'h300);
        check("postflush.imm",   bus.imm,                32'h7);

        present(32'h0000_007F, 32'h400); tick(); tick();
        check("ill.flag",   {31'b0, bus.illegal},   32'h1);
        check("ill.valid",  {31'b0, bus.valid_out}, 32'h1);
        check("ill.opcode", {25'b0, bus.opcode},    32'h7F);
        check("ill.imm",    bus.imm,                32'h0);

        // reset lands in the middle of a stall with or x10,x5,x7 in flight
        present(32'h0072_E533, 32'h500); tick();
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stall = 1'b0;
        check_bubble("midrst");
        tick();
        check("midrst.nop.valid", {31'b0, bus.valid_out}, 32'h0);
        tick();
        check("rstregs.valid", {31'b0, bus.valid_out}, 32'h1);
        check("rstregs.pc",    bus.pc_out,             32'h500);
        check("rstregs.rs1d",  bus.rs1_data,           32'h0);
        check("rstregs.rs2d",  bus.rs2_data,           32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the pipelined RV32I core, directly downstream of the fetch stage. Latches the fetched instruction and PC into an IF/ID register, reads the register file, and generates the immediate. Registers the decoded fields into an ID/EX output register. Also owns the architectural register file, written by the writeback stage, and applies stall and flush requests from the hazard logic.

## Interface
- XLEN, 32: datapath width.
- NREG, 32: architectural register count; x0 is hardwired to zero.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- instruction  in  32  instruction word from fetch.
- pc_in  in  32  PC of `instruction`.
- stall  in  1  load-use stall: hold IF/ID, bubble ID/EX.
- flush  in  1  taken branch/jump: bubble IF/ID and ID/EX.
- wb_en  in  1  register-file write enable.
- wb_rd  in  5  write address.
- wb_data  in  32  write data.
- valid_out  out  1  ID/EX holds a real instruction.
- pc_out  out  32  PC of the decoded instruction.
- rs1_data, rs2_data  out  32 each  operand values.
- imm  out  32  sign-extended immediate.
- rs1, rs2, rd  out  5 each  register indices.
- opcode  out  7; funct3  out  3; funct7  out  7  raw instruction fields.
- illegal  out  1  opcode is not a supported RV32I opcode.

## Operation
- **IF/ID register** (instr_q, pc_q, vld_q):
  - normal cycle: loads `instruction`/`pc_in`, vld_q=1.
  - stall=1: holds its contents.
  - flush=1: loads NOP 0x00000013 with vld_q=0.
  - flush has priority over stall.
- **Register file:**
  - Write on rising edge when wb_en=1 and wb_rd≠0; writes to x0 are ignored, and reads of x0 return 0.
  - Read is combinational from instr_q[19:15] and instr_q[24:20].
  - Write-through bypass: if wb_en=1, wb_rd≠0 and wb_rd equals a read index in the same cycle, that read returns wb_data.
- **Immediate generation**, by opcode:
  - I-type (0x03, 0x13, 0x67): sext(instr[31:20]).
  - S-type (0x23): sext({instr[31:25], instr[11:7]}).
  - B-type (0x63): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0x37, 0x17): {instr[31:12], 12'b0}.
  - J-type (0x6F): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0x33), SYSTEM (0x73), illegal opcodes: 0.
- **illegal**: set when the opcode is none of 0x03, 0x13, 0x17, 0x23, 0x33, 0x37, 0x63, 0x67, 0x6F, 0x73. illegal does not clear valid.
- **ID/EX register**:
  - normal cycle: captures all decoded outputs, with valid_out=vld_q.
  - stall=1 or flush=1: loads a bubble. A bubble is all outputs 0, except opcode=0x13 and valid_out=0.
- Stall is not a state machine; a stall lasts as long as `stall` is held. While stalled, the held instruction re-reads the register file every cycle, so it picks up writes made during the stall.

## Timing
- Reset (rst=1 at an edge):
  - IF/ID = NOP with vld_q=0.
  - ID/EX = bubble.
  - All 32 registers cleared to 0.
- Reset is effective from the next edge. Asserting it mid-stall or mid-flush discards everything in flight.
- Latency: an instruction sampled at edge N appears on the outputs after edge N+1, i.e. 2 edges from fetch output to ID/EX.
- Bypass is same-cycle: a write at edge N is visible to an instruction that is in IF/ID during the cycle ending at edge N.
- A flush while stalled discards the held instruction.
- A write with wb_rd=0 leaves all registers unchanged, including x0.

## Structure
- Shared package `core_pkg`:
  - opcode localparams (OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM);
  - NOP_INSTR = 32'h00000013;
  - XLEN;
  - enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module `regfile`: NREG×XLEN storage with two read ports and one write port, containing the x0 and bypass logic.
- Immediate generation and the pipeline registers stay in `id_stage`.

## Test plan
- **Reset, then basic decode.** Reset; write x5=0x0000_1234 via WB; present `addi x6,x5,-1` (0xFFF28313) at PC 0x40.
  Expect after 2 edges: valid_out=1, pc_out=0x40, rs1_data=0x1234, imm=0xFFFFFFFF, rd=6.
- **Immediate formats.**
  - `sw x2,8(x1)` → imm=8.
  - `beq` with offset −4 → imm=0xFFFFFFFC.
  - `lui x1,0xABCDE` → imm=0xABCDE000.
  - `jal` +2048 → imm=0x800.
- **Bypass and x0.**
  - WB writes x7=0xDEAD_BEEF in the same cycle `add x8,x7,x0` is in IF/ID → rs1_data=0xDEADBEEF, rs2_data=0.
  - Writing x0=0x55 leaves x0 reading 0.
- **Stall.** Hold stall for 2 cycles while `or` is in IF/ID.
  - Expect 2 bubbles (valid_out=0) and `or` emitted once after release.
  - The next fetched instruction is not lost.
- **Flush.** Assert flush for 1 cycle with stall=1 simultaneously → the next 2 output cycles are bubbles, and the held instruction never appears.
- **Illegal and reset mid-run.**
  - Opcode 0x7F → illegal=1, valid_out=1.
  - rst in mid-stream → next outputs are a bubble, and all registers read 0.
